lcd_bus_ctrl: RTL and testbench

Sequencer that owns the character-LCD bus (8-bit data, RS, EN) for the calculator datapath.
- After power-up it runs the fixed controller init sequence on its own.
- It then accepts single byte writes (command or character) from upstream logic over a valid/ready handshake.
- For every byte it generates setup, EN-pulse, hold and execution-wait timing.
- The ALU/display logic never drives EN directly; it only requests writes here.

---
 rtl/lcd_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_ctrl.sv
// Character-LCD bus sequencer: runs the controller init sequence after power-up,
// then turns accepted single-byte writes into setup / EN pulse / hold / execution-wait cycles.
module lcd_bus_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 2,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;
            2'd1:    init_rom = 8'h0E;
            2'd2:    init_rom = 8'h01;
            2'd3:    init_rom = 8'h06;
            default: init_rom = 8'h00;
        endcase
    endfunction

    localparam int MAX_T = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_CMD, T_CLEAR));
    localparam int CW = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PWR_LAST   = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] SETUP_RLD  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EN_RLD     = CW'(T_EN - 1);
    localparam logic [CW-1:0] HOLD_RLD   = CW'(T_HOLD - 1);
    // The last wait cycle is spent in IDLE with wr_ready already high, hence the -2.
    localparam logic [CW-1:0] CMD_RLD    = (T_CMD > 1)   ? CW'(T_CMD - 2)   : {CW{1'b0}};
    localparam logic [CW-1:0] CLR_RLD    = (T_CLEAR > 1) ? CW'(T_CLEAR - 2) : {CW{1'b0}};
    localparam logic          CMD_IS_ONE = (T_CMD == 1);
    localparam logic          CLR_IS_ONE = (T_CLEAR == 1);

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_WAIT      = 3'd5,
        ST_IDLE      = 3'd6
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [1:0]      idx_r;
    logic [7:0]      lcd_data_r;
    logic            lcd_rs_r;
    logic            lcd_en_r;
    logic            wr_ready_r;
    logic            init_done_r;

    logic            long_wait_s;
    logic            wait_one_s;
    logic [CW-1:0]   wait_rld_s;
    logic            finish_s;

    assign lcd_data  = lcd_data_r;
    assign lcd_rs    = lcd_rs_r;
    assign lcd_en    = lcd_en_r;
    assign lcd_rw    = 1'b0;
    assign wr_ready  = wr_ready_r;
    assign init_done = init_done_r;

    // Execution-wait length for the byte on the bus and the end-of-transfer strobe.
    always_comb begin
        long_wait_s = 1'b0;
        wait_one_s  = 1'b0;
        wait_rld_s  = CMD_RLD;
        finish_s    = 1'b0;
        if (!lcd_rs_r && ((lcd_data_r == 8'h01) || (lcd_data_r == 8'h02) || (lcd_data_r == 8'h03))) begin
            long_wait_s = 1'b1;
        end else begin
            long_wait_s = 1'b0;
        end
        if (long_wait_s) begin
            wait_one_s = CLR_IS_ONE;
            wait_rld_s = CLR_RLD;
        end else begin
            wait_one_s = CMD_IS_ONE;
            wait_rld_s = CMD_RLD;
        end
        if ((state_r == ST_HOLD) && (cnt_r == CNT_ZERO) && wait_one_s) begin
            finish_s = 1'b1;
        end else if ((state_r == ST_WAIT) && (cnt_r == CNT_ZERO)) begin
            finish_s = 1'b1;
        end else begin
            finish_s = 1'b0;
        end
    end

    // Sequencer FSM with registered bus and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_PWRUP;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 2'd0;
            lcd_data_r  <= 8'h00;
            lcd_rs_r    <= 1'b0;
            lcd_en_r    <= 1'b0;
            wr_ready_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (cnt_r == PWR_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_INIT_LOAD;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_INIT_LOAD: begin
                    lcd_data_r <= init_rom(idx_r);
                    lcd_rs_r   <= 1'b0;
                    cnt_r      <= SETUP_RLD;
                    state_r    <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt_r == CNT_ZERO) begin
                        lcd_en_r <= 1'b1;
                        cnt_r    <= EN_RLD;
                        state_r  <= ST_PULSE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == CNT_ZERO) begin
                        lcd_en_r <= 1'b0;
                        cnt_r    <= HOLD_RLD;
                        state_r  <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (!wait_one_s) begin
                        cnt_r   <= wait_rld_s;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (wr_valid && wr_ready_r) begin
                        lcd_data_r <= wr_data;
                        lcd_rs_r   <= wr_rs;
                        wr_ready_r <= 1'b0;
                        cnt_r      <= SETUP_RLD;
                        state_r    <= ST_SETUP;
                    end
                end
                default: begin
                    lcd_en_r   <= 1'b0;
                    wr_ready_r <= 1'b0;
                    cnt_r      <= CNT_ZERO;
                    state_r    <= ST_PWRUP;
                end
            endcase

            if (finish_s) begin
                if (init_done_r) begin
                    wr_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end else if (idx_r == 2'd3) begin
                    init_done_r <= 1'b1;
                    wr_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end else begin
                    idx_r   <= idx_r + 2'd1;
                    state_r <= ST_INIT_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: edge-numbered reference model, vector table
// of single writes, and hand sequences for back-to-back, ignored requests and async reset.
module tb_lcd_bus_ctrl;

    localparam int TP  = 20;
    localparam int TS  = 2;
    localparam int TE  = 4;
    localparam int TH  = 2;
    localparam int TC  = 8;
    localparam int TCL = 30;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    lcd_bus_ctrl #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLEAR(TCL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rom [4] = '{8'h38, 8'h0E, 8'h01, 8'h06};
    logic [8:0] pq [$];
    logic       prev_en;

    // Reference model: everything is expressed as edge numbers since reset release.
    int         m_n, m_load, m_end, m_idx, m_next_load;
    bit         m_active, m_ready, m_done, m_en;
    logic [7:0] m_data;
    logic       m_rs;

    task automatic model_reset();
        m_n = 0; m_active = 0; m_ready = 0; m_done = 0; m_en = 0;
        m_idx = 0; m_next_load = TP + 1; m_data = 8'h00; m_rs = 1'b0;
        m_load = 0; m_end = 0;
        prev_en = 1'b0;
        pq.delete();
    endtask

    task automatic model_start(input logic rs, input logic [7:0] d);
        int wt;
        wt = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TCL : TC;
        m_load = m_n; m_rs = rs; m_data = d; m_active = 1;
        m_end = m_n + TS + TE + TH + wt - 1;
    endtask

    task automatic model_step();
        m_n++;
        if (m_ready && wr_valid) begin
            m_ready = 0;
            model_start(wr_rs, wr_data);
        end else if (!m_done && !m_active && m_n == m_next_load) begin
            model_start(1'b0, rom[m_idx]);
        end
        if (m_active && m_n == m_end) begin
            m_active = 0;
            if (m_done) m_ready = 1;
            else if (m_idx == 3) begin m_done = 1; m_ready = 1; end
            else begin m_idx++; m_next_load = m_n + 1; end
        end
        m_en = m_active && (m_n >= m_load + TS) && (m_n < m_load + TS + TE);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("lcd_en", {31'd0, lcd_en}, {31'd0, m_en});
        chk("lcd_data", {24'd0, lcd_data}, {24'd0, m_data});
        chk("lcd_rs", {31'd0, lcd_rs}, {31'd0, m_rs});
        chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
        chk("init_done", {31'd0, init_done}, {31'd0, m_done});
        if (lcd_en && !prev_en) pq.push_back({lcd_rs, lcd_data});
        prev_en = lcd_en;
    endtask

    // One clock: inputs set before the edge are the ones the model consumes.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) model_step();
        else model_reset();
        compare_all();
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] d, output int acc);
        int k;
        k = 0;
        wr_rs = rs; wr_data = d; wr_valid = 1'b1;
        while (!wr_ready && k < 200) begin tick(); k++; end
        chk("accept_ready_timeout", {31'd0, wr_ready}, 32'd1);
        tick();
        acc = cyc;
        chk("accept_data", {23'd0, lcd_rs, lcd_data}, {23'd0, rs, d});
        wr_valid = 1'b0; wr_data = 8'($urandom); wr_rs = 1'($urandom);
    endtask

    // gap = edges from the accept edge to the earliest possible next accept
    task automatic wait_ready(output int gap);
        int k;
        k = 0;
        while (!wr_ready && k < 200) begin tick(); k++; end
        chk("ready_timeout", {31'd0, wr_ready}, 32'd1);
        gap = k + 1;
    endtask

    task automatic check_init_pulses();
        chk("init_pulse_count", pq.size(), 32'd4);
        for (int i = 0; i < 4 && i < pq.size(); i++)
            chk("init_pulse_byte", {23'd0, pq[i]}, {24'd0, rom[i]});
    endtask

    vec_t vecs [9];

    initial begin
        int acc, acc2, gap, k, npulse;

        vecs[0] = '{1'b1, 8'h41, 16};
        vecs[1] = '{1'b0, 8'h01, 38};
        vecs[2] = '{1'b0, 8'h02, 38};
        vecs[3] = '{1'b0, 8'h03, 38};
        vecs[4] = '{1'b0, 8'h04, 16};
        vecs[5] = '{1'b1, 8'h01, 16};
        vecs[6] = '{1'b0, 8'h00, 16};
        vecs[7] = '{1'b1, 8'h4C, 16};
        vecs[8] = '{1'b0, 8'h80, 16};

        rst_n = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
        model_reset();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b1;

        // Request held from power-up: must wait for the whole init sequence.
        wr_rs = 1'b1; wr_data = 8'h55; wr_valid = 1'b1;
        k = 0;
        while (!wr_ready && k < 300) begin tick(); k++; end
        chk("init_done_before_accept", {31'd0, init_done}, 32'd1);
        check_init_pulses();
        write_byte(1'b1, 8'h55, acc);
        wait_ready(gap);
        chk("gap_0x55", gap, 32'd16);

        for (int i = 0; i < 9; i++) begin
            write_byte(vecs[i].rs, vecs[i].data, acc);
            wait_ready(gap);
            chk("vector_gap", gap, vecs[i].gap);
        end

        // Back-to-back: clear then character, second accept on the first possible edge.
        write_byte(1'b0, 8'h01, acc);
        write_byte(1'b0, 8'h4C, acc2);
        chk("b2b_accept_distance", acc2 - acc, 32'd38);
        wait_ready(gap);
        chk("b2b_second_gap", gap, 32'd16);

        // One-cycle request while busy must be ignored.
        npulse = pq.size();
        write_byte(1'b1, 8'h5A, acc);
        tick(); tick();
        chk("busy_ready_low", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("ignored_data", {24'd0, lcd_data}, 32'h5A);
        chk("ignored_rs", {31'd0, lcd_rs}, 32'd1);
        wait_ready(gap);
        chk("ignored_pulse_count", pq.size(), npulse + 1);

        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_rs    = 1'($urandom);
            wr_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;

        // Asynchronous reset while EN is high, then full re-init.
        write_byte(1'b1, 8'h33, acc);
        k = 0;
        while (!lcd_en && k < 100) begin tick(); k++; end
        chk("en_before_reset", {31'd0, lcd_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_en", {31'd0, lcd_en}, 32'd0);
        chk("async_init_done", {31'd0, init_done}, 32'd0);
        chk("async_ready", {31'd0, wr_ready}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        k = 0;
        while (!init_done && k < 300) begin tick(); k++; end
        chk("reinit_done", {31'd0, init_done}, 32'd1);
        check_init_pulses();
        write_byte(1'b1, 8'h7E, acc);
        wait_ready(gap);
        chk("post_reset_gap", gap, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
